// File: rtl/b4_s2p_rcv_if.sv
// Serial receive bus: upstream bit stream in, framed word + status out.
// master = stimulus/consumer side, slave = receiver side.
interface b4_s2p_rcv_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             sin;
  logic             bit_en;
  logic             sync;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             ovr;
  logic             clr_err;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    output sin, bit_en, sync, dout_ready, clr_err,
    input  dout, dout_valid, frame_err, ovr, word_cnt
  );

  modport slave (
    input  sin, bit_en, sync, dout_ready, clr_err,
    output dout, dout_valid, frame_err, ovr, word_cnt
  );
endinterface

// File: rtl/b4_s2p_rcv.sv
// Sync-framed serial-to-parallel receiver, MSB first; word visible the cycle after its last bit.
// Single holding register with valid/ready; a word finishing while it is full and unread is dropped (ovr).
module b4_s2p_rcv #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  b4_s2p_rcv_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {HUNT, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             ferr_set;

  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             ferr_q;
  logic             ovr_q;
  logic [CNT_W-1:0] wcnt_q;
  logic             hold_free;
  logic             ovr_set;

  assign word = {shreg[WIDTH-2:0], bus.sin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    done      = 1'b0;
    ferr_set  = 1'b0;
    if (bus.bit_en) begin
      case (state)
        HUNT: begin
          if (bus.sync) begin
            shreg_nxt = word;
            cnt_nxt   = CW'(1);
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          shreg_nxt = word;
          // A mid-word sync restarts framing, even on what would have been the last bit.
          if (bus.sync && cnt != '0) begin
            ferr_set = 1'b1;
            cnt_nxt  = CW'(1);
          end else if (cnt == CW'(WIDTH - 1)) begin
            done    = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign hold_free = !valid_q || bus.dout_ready;
  assign ovr_set   = done && !hold_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      if (done && hold_free) begin
        dout_q  <= word;
        valid_q <= 1'b1;
        wcnt_q  <= wcnt_q + CNT_W'(1);
      end else if (bus.dout_ready) begin
        valid_q <= 1'b0;
      end
      // Set beats a simultaneous clear.
      ferr_q <= ferr_set || (ferr_q && !bus.clr_err);
      ovr_q  <= ovr_set  || (ovr_q  && !bus.clr_err);
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.ovr        = ovr_q;
  assign bus.word_cnt   = wcnt_q;
endmodule
